// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command FIFO plus a 4-state issue FSM in front of a registered
// 4-op ALU. Each command is issued as a single-cycle one-hot select, the result
// is captured one cycle later and returned on a valid/ready response channel.
// Divide-by-zero is screened before issue and reported through rsp_err.
// Build option: define OPERAND_ISO_EN to zero alu_a/alu_b outside the issue cycle.
module alu_op_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 4,
    parameter int unsigned RW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    output logic [3:0]    alu_sel,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [RW-1:0] alu_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_data,
    output logic [1:0]    rsp_op,
    output logic          rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_mem [DEPTH];
    logic [DW-1:0]   a_mem  [DEPTH];
    logic [DW-1:0]   b_mem  [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            full, empty, push, pop;
    logic [1:0]      head_op;
    logic [DW-1:0]   head_a, head_b;
    logic            div_zero;
    logic [1:0]      op_q;
    logic            err_q;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !rst && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIssue);
    assign head_op   = op_mem[rd_ptr_q];
    assign head_a    = a_mem[rd_ptr_q];
    assign head_b    = b_mem[rd_ptr_q];
    assign div_zero  = (head_op == 2'd2) && (head_b == '0);
    assign rsp_valid = (state_q == StResp);

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= cmd_op;
            a_mem[wr_ptr_q]  <= cmd_a;
            b_mem[wr_ptr_q]  <= cmd_b;
        end
    end

    // FIFO pointers/occupancy, FSM state and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            op_q     <= '0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_op   <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (state_q == StIssue) begin
                op_q  <= head_op;
                err_q <= div_zero;
            end
            if (state_q == StCapt) begin
                rsp_data <= err_q ? {RW{1'b1}} : alu_out;
                rsp_op   <= op_q;
                rsp_err  <= err_q;
            end
        end
    end

    // Next-state and one-hot select decode; a divide by zero is never issued.
    always_comb begin
        state_d = state_q;
        alu_sel = 4'b0000;
        case (state_q)
            // A command pushed this cycle is already the head next cycle.
            StIdle:  if (!empty || push) state_d = StIssue;
            StIssue: begin
                if (!div_zero) begin
                    unique case (head_op)
                        2'd0: alu_sel = 4'b1000;
                        2'd1: alu_sel = 4'b0100;
                        2'd2: alu_sel = 4'b0010;
                        2'd3: alu_sel = 4'b0001;
                    endcase
                end
                state_d = StCapt;
            end
            StCapt:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef OPERAND_ISO_EN
    // Operands only toggle the ALU inputs during the issue cycle.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (state_q == StIssue) begin
            alu_a = head_a;
            alu_b = head_b;
        end
    end
`else
    logic [DW-1:0] alu_a_q, alu_b_q;

    // Loaded on entry to ISSUE so the new operands line up with alu_sel, then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
        end else if ((state_q == StIdle) && (state_d == StIssue)) begin
            alu_a_q <= empty ? cmd_a : head_a;
            alu_b_q <= empty ? cmd_b : head_b;
        end
    end

    assign alu_a = alu_a_q;
    assign alu_b = alu_b_q;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed bench pairing alu_op_issuer with a registered ALU model.
// A queue of accepted commands predicts every response; directed steps pin literals.
module tb_alu_op_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic [3:0] alu_sel;
    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_out = '0;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_op;
    logic       rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t cur;

    alu_op_issuer #(.DEPTH(4), .DW(4), .RW(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Registered ALU, priority sel1 > sel2 > sel3 > sel4.
    always @(posedge clk) begin
        if (alu_sel[3])      alu_out <= {4'b0, alu_a} * {4'b0, alu_b};
        else if (alu_sel[2]) alu_out <= {4'b0, alu_a} + {4'b0, alu_b};
        else if (alu_sel[1]) alu_out <= {4'b0, alu_a} / {4'b0, alu_b};
        else if (alu_sel[0]) alu_out <= {4'b0, alu_a} - {4'b0, alu_b};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input cmd_t c);
        int r;
        case (c.op)
            2'd0:    r = int'(c.a) * int'(c.b);
            2'd1:    r = int'(c.a) + int'(c.b);
            2'd2:    r = (c.b == 0) ? 255 : int'(c.a) / int'(c.b);
            default: r = int'(c.a) - int'(c.b);
        endcase
        return r[7:0];
    endfunction

    function automatic logic [3:0] exp_sel(input cmd_t c);
        case (c.op)
            2'd0:    return 4'b1000;
            2'd1:    return 4'b0100;
            2'd2:    return (c.b == 0) ? 4'b0000 : 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Every-cycle compare against the command queue model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("sel_onehot0", 32'($onehot0(alu_sel)), 32'd1);
            if (alu_sel != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("sel_without_cmd", 32'(alu_sel), 32'd0);
                end else begin
                    cur = exp_q[0];
                    check("sel_code", 32'(alu_sel), 32'(exp_sel(cur)));
                    check("issue_a", 32'(alu_a), 32'(cur.a));
                    check("issue_b", 32'(alu_b), 32'(cur.b));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(exp_data(cur)));
                    check("rsp_op", 32'(rsp_op), 32'(cur.op));
                    check("rsp_err", 32'(rsp_err), 32'((cur.op == 2'd2) && (cur.b == 0)));
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back('{op: cmd_op, a: cmd_a, b: cmd_b});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = cmd_ready;
            cyc();
        end
        if (!done) check("send_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] data, input logic err,
                            output logic [3:0] sel_seen);
        bit done = 0;
        sel_seen = 4'b0000;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            sel_seen = sel_seen | alu_sel;
            if (rsp_valid && rsp_ready) begin
                done = 1;
                check({name, "_data"}, 32'(rsp_data), 32'(data));
                check({name, "_err"}, 32'(rsp_err), 32'(err));
            end
            cyc();
        end
        if (!done) check({name, "_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] sel_seen;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_op_err", 32'({rsp_op, rsp_err}), 32'd0);
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cyc();

        // 1: MUL 15*15, latency
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 4'd15; cmd_b = 4'd15;
        @(negedge clk);
        check("t1_accept", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_issue_sel", 32'(alu_sel), 32'h8);
        cyc();
        @(negedge clk);
        check("t1_capt_sel", 32'(alu_sel), 32'h0);
        check("t1_capt_valid", 32'(rsp_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_data", 32'(rsp_data), 32'd225);
        check("t1_rsp_op_err", 32'({rsp_op, rsp_err}), 32'd0);
        cyc();

        // 2: ADD then SUB back-to-back
        send(2'd1, 4'd9, 4'd8);
        send(2'd3, 4'd3, 4'd5);
        wait_rsp("t2_add", 8'd17, 1'b0, sel_seen);
        wait_rsp("t2_sub", 8'hFE, 1'b0, sel_seen);

        // 3: DIV, then DIV by zero
        send(2'd2, 4'd13, 4'd4);
        wait_rsp("t3_div", 8'd3, 1'b0, sel_seen);
        send(2'd2, 4'd7, 4'd0);
        wait_rsp("t3_div0", 8'hFF, 1'b1, sel_seen);
        check("t3_div0_sel", 32'(sel_seen), 32'd0);

        // 4: stalled response, FIFO fills, then drains in order
        rsp_ready = 1'b0;
        send(2'd0, 4'd3, 4'd4);
        send(2'd1, 4'd15, 4'd1);
        send(2'd3, 4'd0, 4'd1);
        send(2'd2, 4'd15, 4'd2);
        send(2'd0, 4'd2, 4'd7);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 4'd1; cmd_b = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_full_ready", 32'(cmd_ready), 32'd0);
            check("t4_stall_valid", 32'(rsp_valid), 32'd1);
            check("t4_stall_data", 32'(rsp_data), 32'd12);
            cyc();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp("t4_r1", 8'd12, 1'b0, sel_seen);
        wait_rsp("t4_r2", 8'd16, 1'b0, sel_seen);
        wait_rsp("t4_r3", 8'hFF, 1'b0, sel_seen);
        wait_rsp("t4_r4", 8'd7, 1'b0, sel_seen);
        wait_rsp("t4_r5", 8'd14, 1'b0, sel_seen);

        // 5: reset during CAPT of the second op with two more queued
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_op = (i == 1) ? 2'd0 : 2'd1;
            cmd_a = 4'(i + 1);
            cmd_b = 4'(i + 2);
            @(negedge clk);
            check("t5_accept", 32'(cmd_ready), 32'd1);
            cyc();
        end
        cmd_valid = 1'b0;
        cyc();
        @(negedge clk);
        check("t5_issue_b", 32'(alu_sel), 32'h8);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 32'(cmd_ready), 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_sel", 32'(alu_sel), 32'd0);
        check("t5_post_valid", 32'(rsp_valid), 32'd0);
        check("t5_post_ready", 32'(cmd_ready), 32'd1);
        cyc();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_quiet", 32'({alu_sel, 3'b0, rsp_valid}), 32'd0);
            cyc();
        end

        // 6: operand behaviour outside ISSUE
        send(2'd0, 4'd5, 4'd6);
        wait_rsp("t6_mul", 8'd30, 1'b0, sel_seen);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
`ifdef OPERAND_ISO_EN
            check("t6_iso_ab", 32'({alu_a, alu_b}), 32'h00);
`else
            check("t6_hold_ab", 32'({alu_a, alu_b}), 32'h56);
`endif
            cyc();
        end
        check("model_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
